motion_driver: RTL and testbench
================================

# motion_driver

Consumer side of the processor's motion registers. Takes the four speed/direction words the register file exports (ySpeed, yDirection, xSpeed, xDirection) and converts them into per-axis step pulses and bounded X/Y position counters for the display/sprite logic. A clock divider generates a base tick. On every tick, each axis adds its speed to a phase accumulator and steps one position unit on accumulator carry.

## Interface
Parameters:
- TICK_DIV, 1000: clock cycles per base tick (≥2).
- X_MAX, 639: maximum X position.
- Y_MAX, 479: maximum Y position.
- X_START, 320: X position after reset.
- Y_START, 240: Y position after reset.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- ctrl_reset_n  in  1  reset; synchronous, active-low.
- enable  in  1  high = run; low = freeze divider, accumulators and positions.
- xSpeed  in  32  X speed word; bits [7:0] used, rest ignored.
- xDirection  in  32  X direction; bit 0: 1 = +X, 0 = −X; rest ignored.
- ySpeed  in  32  Y speed word; bits [7:0] used.
- yDirection  in  32  Y direction; bit 0: 1 = +Y, 0 = −Y.
- tick  out  1  one-cycle pulse per base tick.
- xStep, yStep  out  1  one-cycle pulse when the axis attempts a step.
- xPos  out  10  current X position.
- yPos  out  10  current Y position.
- xHit, yHit  out  1  one-cycle pulse when a step is blocked (or wraps) at a boundary.

## Operation
- Divider: counts 0..TICK_DIV−1 while enable is high. At TICK_DIV−1 it asserts tick for one cycle and returns to 0. It holds its value while enable is low.
- Per axis on a tick cycle: {carry, acc[7:0]} = acc + speed[7:0]. The new acc is stored. carry = step request.
- Speed s gives s steps per 256 ticks. s = 0 means stopped. The accumulator keeps its value when speed changes, so no phase is lost.
- Speed and direction are sampled only on the tick cycle. Changes between ticks take effect at the next tick.
- A step request moves the position ±1 according to direction bit 0.
- Boundary, default build: a step request to −1 below 0, or past MAX, leaves the position unchanged and pulses the hit output. The step output still pulses.
- Reset values: divider = 0, acc = 0, xPos = X_START, yPos = Y_START. tick, xStep, yStep, xHit and yHit are all 0.
- Reset takes priority over enable and over a tick in the same cycle.
- Reset mid-operation discards accumulated phase. After reset, the first tick occurs TICK_DIV cycles after ctrl_reset_n goes high.
- The X and Y axes are fully independent. Simultaneous steps and hits on both axes are allowed.

## Timing
- tick is registered and asserts on the cycle after the divider reaches TICK_DIV−1. The period is exactly TICK_DIV cycles.
- Step/hit/position latency: xStep/yStep, xHit/yHit and the updated xPos/yPos appear together, one cycle after tick.
- Every output is driven directly from a flop; there is no combinational input-to-output path.
- enable falling on a tick cycle: that tick completes normally. Processing stops from the next cycle.

## Configuration
- WRAP_EN defined: positions wrap instead of saturating.
  - −1 from 0 goes to MAX; +1 from MAX goes to 0.
  - The hit output pulses on each wrap.
- WRAP_EN undefined: saturating behaviour as described in Operation.

## Structure
- motion_pkg holds:
  - POS_W = 10, SPEED_W = 8, ACC_W = 8.
  - The direction encoding constants DIR_POS = 1 and DIR_NEG = 0.
- Sub-module axis_stepper, instantiated once for X and once for Y. Parameters: MAX, START. It contains the accumulator, the position counter, the boundary/wrap logic and the step/hit output flops.
- motion_driver contains the tick divider and the two axis_stepper instances.

## Test plan
All scenarios use TICK_DIV = 4.
1. Reset: hold ctrl_reset_n low for 3 cycles with nonzero speeds → xPos = 320, yPos = 240, all pulse outputs 0. The first tick comes 4 cycles after release.
2. xSpeed = 128, xDirection = 1, 16 ticks → xStep pulses on every 2nd tick (every 8 cycles), ending at xPos = 328. yPos stays 240 with ySpeed = 0.
3. xSpeed = 64, then changed to 0 mid-run → steps every 4 ticks, then none for 100 ticks. The acc value is retained; restoring 64 gives the next step after the remaining phase.
4. yPos driven to 0 with ySpeed = 255, yDirection = 0:
   - default build: further steps hold yPos = 0, and yHit pulses with each yStep.
   - with WRAP_EN: the next step gives yPos = 479 and yHit pulses once.
5. xPos at 639, xDirection = 1, xSpeed = 255 → xPos stays 639 and xHit pulses. On the same ticks, a Y step proceeds normally.
6. enable low for 20 cycles mid-run → tick, steps and positions frozen; resuming continues at the same divider count. Reset asserted on a tick cycle → no step, reset values restored.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared widths, direction encoding and accumulator helper for the motion driver.
package motion_pkg;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned SPEED_W = 8;
    localparam int unsigned ACC_W   = 8;

    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_e;

    // Returns {carry, sum}; the carry is the step request.
    function automatic logic [ACC_W:0] acc_add(
        input logic [ACC_W-1:0]   acc,
        input logic [SPEED_W-1:0] spd
    );
        return {1'b0, acc} + {1'b0, spd};
    endfunction

endpackage

// File: rtl/motion_driver_axis_stepper.sv
// One motion axis: phase accumulator, bounded position counter and step/hit flops.
// Macro WRAP_EN selects wrap-around at the bounds instead of saturation.
module axis_stepper
    import motion_pkg::*;
#(
    parameter int unsigned MAX   = 639,
    parameter int unsigned START = 320
) (
    input  logic               clock,
    input  logic               ctrl_reset_n,
    input  logic               tick_i,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic               dir_i,
    output logic               step_o,
    output logic               hit_o,
    output logic [POS_W-1:0]   pos_o
);

    localparam logic [POS_W-1:0] MAX_P   = POS_W'(MAX);
    localparam logic [POS_W-1:0] START_P = POS_W'(START);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    logic             hit_q, hit_d;

    logic             carry;
    logic [ACC_W-1:0] acc_sum;
    logic             dir_up;
    logic             blocked;

    always_comb begin
        {carry, acc_sum} = acc_add(acc_q, speed_i);
        dir_up           = (dir_e'(dir_i) == DIR_POS);
        blocked          = dir_up ? (pos_q == MAX_P) : (pos_q == '0);
    end

    always_comb begin
        acc_d  = acc_q;
        pos_d  = pos_q;
        step_d = 1'b0;
        hit_d  = 1'b0;
        if (tick_i) begin
            acc_d  = acc_sum;
            step_d = carry;
            if (carry) begin
                if (blocked) begin
                    hit_d = 1'b1;
`ifdef WRAP_EN
                    pos_d = dir_up ? '0 : MAX_P;
`else
                    pos_d = pos_q;
`endif
                end else if (dir_up) begin
                    pos_d = pos_q + POS_W'(1);
                end else begin
                    pos_d = pos_q - POS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            acc_q  <= '0;
            pos_q  <= START_P;
            step_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            pos_q  <= pos_d;
            step_q <= step_d;
            hit_q  <= hit_d;
        end
    end

    assign step_o = step_q;
    assign hit_o  = hit_q;
    assign pos_o  = pos_q;

endmodule

// File: rtl/motion_driver.sv
// Motion register consumer: base tick divider feeding independent X and Y steppers.
// Macro WRAP_EN (see axis_stepper) switches both axes to wrap-around bounds.
module motion_driver
    import motion_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned X_START  = 320,
    parameter int unsigned Y_START  = 240
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        enable,
    input  logic [31:0] xSpeed,
    input  logic [31:0] xDirection,
    input  logic [31:0] ySpeed,
    input  logic [31:0] yDirection,
    output logic        tick,
    output logic        xStep,
    output logic        yStep,
    output logic [9:0]  xPos,
    output logic [9:0]  yPos,
    output logic        xHit,
    output logic        yHit
);

    localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             unused_bits;

    always_comb begin
        unused_bits = ^{xSpeed[31:SPEED_W], ySpeed[31:SPEED_W],
                        xDirection[31:1], yDirection[31:1]};
    end

    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (enable) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    // Steppers act on the registered tick, so a tick already issued completes even if enable drops.
    axis_stepper #(
        .MAX   (X_MAX),
        .START (X_START)
    ) u_x_axis (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .tick_i       (tick_q),
        .speed_i      (xSpeed[SPEED_W-1:0]),
        .dir_i        (xDirection[0]),
        .step_o       (xStep),
        .hit_o        (xHit),
        .pos_o        (xPos)
    );

    axis_stepper #(
        .MAX   (Y_MAX),
        .START (Y_START)
    ) u_y_axis (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .tick_i       (tick_q),
        .speed_i      (ySpeed[SPEED_W-1:0]),
        .dir_i        (yDirection[0]),
        .step_o       (yStep),
        .hit_o        (yHit),
        .pos_o        (yPos)
    );

endmodule

// File: tb/tb_motion_driver.sv
// Self-checking bench for motion_driver: scenario table, corner sequences and random run vs. a reference model.
module tb_motion_driver;

    localparam int TD = 4;
    localparam int XM = 639;
    localparam int YM = 479;
    localparam int XS = 320;
    localparam int YS = 240;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        enable;
    logic [31:0] xSpeed, xDirection, ySpeed, yDirection;
    logic        tick, xStep, yStep, xHit, yHit;
    logic [9:0]  xPos, yPos;

    always #5 clock = ~clock;

    motion_driver #(
        .TICK_DIV (TD),
        .X_MAX    (XM),
        .Y_MAX    (YM),
        .X_START  (XS),
        .Y_START  (YS)
    ) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .enable       (enable),
        .xSpeed       (xSpeed),
        .xDirection   (xDirection),
        .ySpeed       (ySpeed),
        .yDirection   (yDirection),
        .tick         (tick),
        .xStep        (xStep),
        .yStep        (yStep),
        .xPos         (xPos),
        .yPos         (yPos),
        .xHit         (xHit),
        .yHit         (yHit)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers).
    int m_div, m_xacc, m_yacc, m_xpos, m_ypos;
    bit m_tick, m_xstep, m_ystep, m_xhit, m_yhit;

    int cnt_xs, cnt_ys, cnt_xh, cnt_yh;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic axis_model(input int spd, input bit dir, input int mx,
                              inout int acc, inout int pos, output bit step, output bit hit);
        int sum, tgt;
        sum  = acc + spd;
        step = (sum >= 256);
        acc  = sum % 256;
        hit  = 1'b0;
        if (step) begin
            tgt = dir ? pos + 1 : pos - 1;
            if (tgt < 0 || tgt > mx) begin
                hit = 1'b1;
`ifdef WRAP_EN
                pos = (tgt < 0) ? mx : 0;
`endif
            end else begin
                pos = tgt;
            end
        end
    endtask

    task automatic model_update(input bit r, input bit e, input int xs, input bit xd,
                                input int ys, input bit yd);
        bit nt;
        if (!r) begin
            m_div = 0; m_xacc = 0; m_yacc = 0; m_xpos = XS; m_ypos = YS;
            m_tick = 0; m_xstep = 0; m_ystep = 0; m_xhit = 0; m_yhit = 0;
        end else begin
            nt = e && (m_div == TD - 1);
            if (e) m_div = (m_div == TD - 1) ? 0 : m_div + 1;
            if (m_tick) begin
                axis_model(xs, xd, XM, m_xacc, m_xpos, m_xstep, m_xhit);
                axis_model(ys, yd, YM, m_yacc, m_ypos, m_ystep, m_yhit);
            end else begin
                m_xstep = 0; m_ystep = 0; m_xhit = 0; m_yhit = 0;
            end
            m_tick = nt;
        end
    endtask

    task automatic cycle(input bit r, input bit e, input logic [31:0] xs, input logic [31:0] xd,
                         input logic [31:0] ys, input logic [31:0] yd);
        ctrl_reset_n = r;
        enable       = e;
        xSpeed       = xs;
        xDirection   = xd;
        ySpeed       = ys;
        yDirection   = yd;
        model_update(r, e, int'(xs & 32'hFF), xd[0], int'(ys & 32'hFF), yd[0]);
        @(posedge clock);
        @(negedge clock);
        chk("tick",  int'(tick),  int'(m_tick));
        chk("xStep", int'(xStep), int'(m_xstep));
        chk("yStep", int'(yStep), int'(m_ystep));
        chk("xHit",  int'(xHit),  int'(m_xhit));
        chk("yHit",  int'(yHit),  int'(m_yhit));
        chk("xPos",  int'(xPos),  m_xpos);
        chk("yPos",  int'(yPos),  m_ypos);
        cnt_xs += int'(xStep);
        cnt_ys += int'(yStep);
        cnt_xh += int'(xHit);
        cnt_yh += int'(yHit);
    endtask

    // Runs cycles until tick is seen; n = cycles taken or -1 if the budget expires.
    task automatic run_until_tick(input logic [31:0] xs, output int n);
        bit seen;
        n    = -1;
        seen = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (!seen) begin
                cycle(1'b1, 1'b1, xs, 32'd1, 32'd0, 32'd1);
                if (tick) begin
                    n    = i;
                    seen = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        bit rst_n;
        bit en;
        int xs, xd, ys, yd;
        int n;
        int xpos, ypos;
        int xst, yst, xh, yh;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;

        vecs[0]  = '{0, 1, 200, 1, 100, 1,    3, 320, 240,   0,   0, 0, 0};
        vecs[1]  = '{1, 1, 128, 1,   0, 1,   65, 328, 240,   8,   0, 0, 0};
        vecs[2]  = '{1, 1,  64, 1,   0, 1,   32, 330, 240,   2,   0, 0, 0};
        vecs[3]  = '{1, 1,  64, 1,   0, 1,   12, 330, 240,   0,   0, 0, 0};
        vecs[4]  = '{1, 1,   0, 1,   0, 1,  400, 330, 240,   0,   0, 0, 0};
        vecs[5]  = '{1, 1,  64, 1,   0, 1,    4, 331, 240,   1,   0, 0, 0};
        vecs[6]  = '{1, 1,   0, 1, 255, 0,  964, 331,   0,   0, 240, 0, 0};
`ifdef WRAP_EN
        vecs[7]  = '{1, 1,   0, 1, 255, 0,   20, 331, 475,   0,   5, 0, 1};
        vecs[8]  = '{1, 1, 255, 1,   0, 1, 1240, 639, 475, 308,   0, 0, 0};
        vecs[9]  = '{1, 1, 255, 1, 128, 1,   32, 639, 479,   8,   4, 8, 0};
        vecs[10] = '{1, 0, 255, 1, 128, 1,   20, 639, 479,   0,   0, 0, 0};
        vecs[11] = '{1, 1,  64, 0,   0, 1,    4, 638, 479,   1,   0, 0, 0};
`else
        vecs[7]  = '{1, 1,   0, 1, 255, 0,   20, 331,   0,   0,   5, 0, 5};
        vecs[8]  = '{1, 1, 255, 1,   0, 1, 1240, 639,   0, 308,   0, 0, 0};
        vecs[9]  = '{1, 1, 255, 1, 128, 1,   32, 639,   4,   8,   4, 8, 0};
        vecs[10] = '{1, 0, 255, 1, 128, 1,   20, 639,   4,   0,   0, 0, 0};
        vecs[11] = '{1, 1,  64, 0,   0, 1,    4, 638,   4,   1,   0, 0, 0};
`endif

        // Scenario table
        for (int v = 0; v < 12; v++) begin
            cnt_xs = 0; cnt_ys = 0; cnt_xh = 0; cnt_yh = 0;
            for (int c = 0; c < vecs[v].n; c++) begin
                cycle(vecs[v].rst_n, vecs[v].en, 32'(vecs[v].xs), 32'(vecs[v].xd),
                      32'(vecs[v].ys), 32'(vecs[v].yd));
            end
            chk($sformatf("vec%0d xPos", v),   int'(xPos), vecs[v].xpos);
            chk($sformatf("vec%0d yPos", v),   int'(yPos), vecs[v].ypos);
            chk($sformatf("vec%0d xSteps", v), cnt_xs,     vecs[v].xst);
            chk($sformatf("vec%0d ySteps", v), cnt_ys,     vecs[v].yst);
            chk($sformatf("vec%0d xHits", v),  cnt_xh,     vecs[v].xh);
            chk($sformatf("vec%0d yHits", v),  cnt_yh,     vecs[v].yh);
        end

        // Enable falling on a tick cycle: that tick still completes
        cycle(1'b0, 1'b1, 32'd200, 32'd1, 32'd0, 32'd1);
        cycle(1'b0, 1'b1, 32'd200, 32'd1, 32'd0, 32'd1);
        run_until_tick(32'd200, n);
        chk("first tick latency", n, 4);
        run_until_tick(32'd200, n);
        chk("tick period", n, 4);
        cycle(1'b1, 1'b0, 32'd200, 32'd1, 32'd0, 32'd1);
        chk("enfall xStep", int'(xStep), 1);
        chk("enfall xPos",  int'(xPos), 321);
        cnt_xs = 0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, 1'b0, 32'd255, 32'd1, 32'd255, 32'd1);
            n += int'(tick);
        end
        chk("frozen ticks", n, 0);
        chk("frozen steps", cnt_xs, 0);
        chk("frozen xPos", int'(xPos), 321);

        // Reset landing on a tick cycle discards the step and the phase
        cycle(1'b0, 1'b1, 32'd200, 32'd1, 32'd0, 32'd1);
        run_until_tick(32'd200, n);
        chk("rst seq tick1", n, 4);
        run_until_tick(32'd200, n);
        chk("rst seq tick2", n, 4);
        cycle(1'b0, 1'b1, 32'd200, 32'd1, 32'd0, 32'd1);
        chk("rst-on-tick xStep", int'(xStep), 0);
        chk("rst-on-tick xPos",  int'(xPos), 320);
        chk("rst-on-tick tick",  int'(tick), 0);
        run_until_tick(32'd200, n);
        chk("post-rst tick latency", n, 4);
        cycle(1'b1, 1'b1, 32'd200, 32'd1, 32'd0, 32'd1);
        chk("post-rst phase cleared", int'(xStep), 0);

        // Randomized run against the reference model
        begin
            logic [31:0] rxs, rxd, rys, ryd;
            bit r, e;
            rxs = 0; rxd = 0; rys = 0; ryd = 0;
            cycle(1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
            for (int c = 0; c < 3000; c++) begin
                if (c % 50 == 0) begin
                    rxs = $urandom;
                    rxd = $urandom;
                    rys = $urandom;
                    ryd = $urandom;
                end
                r = ($urandom_range(0, 499) != 0);
                e = ($urandom_range(0, 9) != 0);
                cycle(r, e, rxs, rxd, rys, ryd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
